// File: rtl/alu_exec_stage.sv
// Execute-stage ALU behind a valid/ready input and a registered valid/ready output.
// A two-entry skid (OR + SR) keeps full throughput without a comb out_ready->in_ready path.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           state_q, state_d;
  entry_t           or_q, or_d;
  entry_t           sr_q, sr_d;
  entry_t           new_e;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             slt;
  logic             accept;

  assign slt = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_control)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a | src_b;
      3'b011:  alu_res = src_a & src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_ill = 1'b1;
    endcase
    new_e.result  = alu_res;
    new_e.zero    = (alu_res == '0);
    new_e.illegal = alu_ill;
  end

  // in_ready depends on state only, so downstream ready never reaches upstream combinationally
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          or_d    = new_e;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && out_ready) begin
          or_d = new_e;
        end else if (accept) begin
          sr_d    = new_e;
          state_d = S_TWO;
        end else if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_ready) begin
          or_d    = sr_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      or_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sr_q    <= sr_d;
    end
  end

  assign result  = or_q.result;
  assign zero    = or_q.zero;
  assign illegal = or_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table, backpressure, streaming and async reset.
module tb_alu_exec_stage;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a, src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int passed = 0;
  int total  = 0;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_control = c; src_a = a; src_b = b;
  endtask

  // Reference expectations for the streaming test
  function automatic logic [32:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    r = 32'h0; il = 1'b0;
    case (c)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a | b;
      3'b011: r = a & b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction

  initial begin
    logic [32:0] exp_s[16];
    logic [2:0]  sc[16];
    logic [31:0] sa[16], sb[16];

    vecs[0]  = '{3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0};
    vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[3]  = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[4]  = '{3'b101, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{3'b010, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0};
    vecs[6]  = '{3'b011, 32'hF0,       32'h0F,       32'h0,        1'b1, 1'b0};
    vecs[7]  = '{3'b100, 32'd9,        32'd9,        32'h0,        1'b1, 1'b1};
    vecs[8]  = '{3'b110, 32'd9,        32'd9,        32'h0,        1'b1, 1'b1};
    vecs[9]  = '{3'b111, 32'd9,        32'd9,        32'h0,        1'b1, 1'b1};
    vecs[10] = '{3'b001, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};
    vecs[12] = '{3'b011, 32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b0};
    vecs[13] = '{3'b101, 32'd7,        32'd5,        32'd0,        1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 3'b000; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_result",    result,             32'd0);
    check("rst_zero",      {31'b0, zero},      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-op vectors: one cycle latency, then drained
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ctl, vecs[i].a, vecs[i].b);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i),   {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d_result", i),  result,             vecs[i].res);
      check($sformatf("v%0d_zero", i),    {31'b0, zero},      {31'b0, vecs[i].z});
      check($sformatf("v%0d_illegal", i), {31'b0, illegal},   {31'b0, vecs[i].ill});
      @(negedge clk);
      check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
    end

    // Backpressure: A, B, C with out_ready low
    out_ready = 1'b0;
    drive(3'b000, 32'd100, 32'd1);                 // A = 101
    @(negedge clk);
    check("bp_a_valid",   {31'b0, out_valid}, 32'd1);
    check("bp_a_inrdy",   {31'b0, in_ready},  32'd1);
    check("bp_a_result",  result,             32'd101);
    drive(3'b000, 32'd200, 32'd2);                 // B = 202
    @(negedge clk);
    check("bp_b_inrdy",   {31'b0, in_ready},  32'd0);
    check("bp_hold_a1",   result,             32'd101);
    drive(3'b001, 32'd300, 32'd3);                 // C = 297, must be held off
    @(negedge clk);
    check("bp_c_inrdy",   {31'b0, in_ready},  32'd0);
    check("bp_hold_a2",   result,             32'd101);
    check("bp_hold_zero", {31'b0, zero},      32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_out",     result,             32'd202);
    check("bp_inrdy_back",{31'b0, in_ready},  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_c_out",     result,             32'd297);
    check("bp_c_valid",   {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_empty",     {31'b0, out_valid}, 32'd0);

    // Full throughput: 16 back-to-back ops, illegal codes included
    for (int i = 0; i < 16; i++) begin
      sc[i] = 3'(i % 8);
      sa[i] = 32'h1234_5678 * (i + 1) - 32'd77;
      sb[i] = (i % 3 == 0) ? sa[i] : 32'h0F0F_0F0F ^ (i * 32'h1001);
      exp_s[i] = ref_alu(sc[i], sa[i], sb[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive(sc[i], sa[i], sb[i]);
      else in_valid = 1'b0;
      if (i > 0) begin
        check($sformatf("tp%0d_valid", i-1),  {31'b0, out_valid}, 32'd1);
        check($sformatf("tp%0d_result", i-1), result,             exp_s[i-1][31:0]);
        check($sformatf("tp%0d_illegal", i-1),{31'b0, illegal},   {31'b0, exp_s[i-1][32]});
        check($sformatf("tp%0d_zero", i-1),   {31'b0, zero},
              {31'b0, exp_s[i-1][31:0] == 32'h0});
      end
      check($sformatf("tp%0d_inrdy", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
    end
    check("tp_drained", {31'b0, out_valid}, 32'd0);

    // Async reset while in TWO
    out_ready = 1'b0;
    drive(3'b000, 32'd40, 32'd2);
    @(negedge clk);
    drive(3'b000, 32'd50, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    check("rr_two", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rr_valid", {31'b0, out_valid}, 32'd0);
    check("rr_result", result,            32'd0);
    check("rr_inrdy", {31'b0, in_ready},  32'd1);
    drive(3'b000, 32'd8, 32'd8);   // must be ignored while reset is held
    out_ready = 1'b1;
    @(negedge clk);
    check("rr_no_update", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rr_idle", {31'b0, out_valid}, 32'd0);
    drive(3'b010, 32'hA0, 32'h05);
    @(negedge clk);
    in_valid = 1'b0;
    check("rr_new_valid",  {31'b0, out_valid}, 32'd1);
    check("rr_new_result", result,             32'hA5);
    @(negedge clk);
    check("rr_no_ghost", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
